mem_port_arbiter: RTL

//  Shares the single 64-bit data memory port (we/a/wd/rd, write on posedge, combinational read)

---
 rtl/mem_port_arbiter_if.sv | 31 +++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the memory port and mem_port_arbiter.
// The arbiter uses the slave view; the requesters and memory model use the master view.
interface mem_port_arbiter_if #(
  parameter int AW = 64,
  parameter int DW = 64
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wd;
  logic          d_ack;
  logic [DW-1:0] rdata;
  logic          err;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wd, mem_rd,
    output i_ack, d_ack, rdata, err, mem_we, mem_a, mem_wd
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wd, mem_rd,
    input  i_ack, d_ack, rdata, err, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between instruction fetch (read-only) and load/store.
// Each access runs IDLE -> BUSY -> ACK; read data is registered, misaligned accesses are flagged.
//
//   state | meaning
//   IDLE  | waiting for a request; arbitrates and latches the granted access
//   BUSY  | memory port driven for one cycle; read data captured on the closing edge
//   ACK   | owner's ack pulse high; requests are not sampled
module mem_port_arbiter #(
  parameter int AW = 64,
  parameter int DW = 64,
  parameter bit RR = 1'b1
) (
  input logic                clk,
  input logic                reset,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  owner_t        last_q, last_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wd_q, wd_d;
  logic          we_q, we_d;
  logic          bad_q, bad_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          i_ack_q, i_ack_d;
  logic          d_ack_q, d_ack_d;
  logic          err_q, err_d;

  owner_t        sel;
  logic [AW-1:0] sel_addr;
  logic          sel_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      last_q  <= OWN_D;
      addr_q  <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      bad_q   <= 1'b0;
      rdata_q <= '0;
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      bad_q   <= bad_d;
      rdata_q <= rdata_d;
      i_ack_q <= i_ack_d;
      d_ack_q <= d_ack_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    we_d     = we_q;
    bad_d    = bad_q;
    rdata_d  = rdata_q;
    i_ack_d  = i_ack_q;
    d_ack_d  = d_ack_q;
    err_d    = err_q;
    sel      = OWN_I;
    sel_addr = bus.i_addr;
    sel_we   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          // On conflict, round-robin favours whoever was not served last
          if (bus.i_req && bus.d_req) begin
            if (RR) sel = (last_q == OWN_D) ? OWN_I : OWN_D;
            else    sel = OWN_D;
          end else begin
            sel = bus.d_req ? OWN_D : OWN_I;
          end
          sel_addr = (sel == OWN_D) ? bus.d_addr : bus.i_addr;
          sel_we   = (sel == OWN_D) && bus.d_we;
          owner_d  = sel;
          last_d   = sel;
          addr_d   = sel_addr;
          we_d     = sel_we;
          wd_d     = bus.d_wd;
          // Writes are 8-byte granular; reads only need 4-byte alignment
          bad_d    = (sel_addr[1:0] != 2'b00) || (sel_we && sel_addr[2]);
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (!we_q && !bad_q) rdata_d = bus.mem_rd;
        i_ack_d = (owner_q == OWN_I);
        d_ack_d = (owner_q == OWN_D);
        err_d   = bad_q;
        state_d = ACK;
      end
      ACK: begin
        i_ack_d = 1'b0;
        d_ack_d = 1'b0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        i_ack_d = 1'b0;
        d_ack_d = 1'b0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Decoded straight from state so that reset removes the write strobe without waiting for a clock
  assign bus.mem_we = (state_q == BUSY) && we_q && !bad_q;
  assign bus.mem_a  = addr_q;
  assign bus.mem_wd = wd_q;
  assign bus.rdata  = rdata_q;
  assign bus.i_ack  = i_ack_q;
  assign bus.d_ack  = d_ack_q;
  assign bus.err    = err_q;

endmodule
